// File: rtl/cska_share_arbiter.sv
// One 32-bit carry-skip adder shared by NREQ requesters behind a result slot.
// Define CSKA_ARB_ROUND_ROBIN_EN for round-robin grant; otherwise fixed priority.
module cska #(
    parameter int W   = 32,
    parameter int BLK = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);
    logic c;
    logic bc;
    logic allp;
    logic p;

    // Ripple inside each block; the block carry skips when all bits propagate.
    always_comb begin
        c     = 1'b0;
        bc    = 1'b0;
        allp  = 1'b0;
        p     = 1'b0;
        sum_o = '0;
        for (int g = 0; g < W / BLK; g++) begin
            bc   = c;
            allp = 1'b1;
            for (int j = 0; j < BLK; j++) begin
                p                = a_i[g*BLK+j] ^ b_i[g*BLK+j];
                sum_o[g*BLK+j]   = p ^ bc;
                bc               = (a_i[g*BLK+j] & b_i[g*BLK+j]) | (p & bc);
                allp             = allp & p;
            end
            c = allp ? c : bc;
        end
        cout_o = c;
    end
endmodule

module cska_share_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic [NREQ-1:0]  req_ready,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_sum,
    output logic             res_cout,
    output logic [IDW-1:0]   res_id
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic [31:0]     sum_q, sum_d;
    logic            cout_q, cout_d;
    logic [IDW-1:0]  id_q, id_d;

    logic            slot_free;
    logic            xfer;
    logic            found;
    logic [NREQ-1:0] rot_v;
    logic [NREQ-1:0] rot_g;
    logic [NREQ-1:0] gnt_raw;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_id;
    logic [31:0]     add_a, add_b, add_sum;
    logic            add_cout;

    assign slot_free = (state_q == EMPTY) || res_ready;

`ifdef CSKA_ARB_ROUND_ROBIN_EN
    logic [IDW-1:0] rr_q, rr_d;

    // Rotate so that bit 0 is the requester at rr_q, then rotate the grant back.
    assign rot_v   = (req_valid >> rr_q) | (req_valid << (NREQ - rr_q));
    assign gnt_raw = (rot_g << rr_q) | (rot_g >> (NREQ - rr_q));

    always_comb begin
        rr_d = rr_q;
        if (xfer) begin
            rr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign rot_v   = req_valid;
    assign gnt_raw = rot_g;
`endif

    always_comb begin
        rot_g = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && rot_v[k]) begin
                rot_g[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign gnt       = (rst_n && slot_free) ? gnt_raw : '0;
    assign req_ready = gnt;
    assign xfer      = |gnt;

    always_comb begin
        gnt_id = '0;
        add_a  = '0;
        add_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                gnt_id = IDW'(i);
            end
            add_a = add_a | (req_a[i*32 +: 32] & {32{gnt[i]}});
            add_b = add_b | (req_b[i*32 +: 32] & {32{gnt[i]}});
        end
    end

    cska #(
        .W   (32),
        .BLK (4)
    ) u_cska (
        .a_i    (add_a),
        .b_i    (add_b),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        id_d    = id_q;
        unique case (state_q)
            EMPTY: begin
                if (xfer) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (res_ready && !xfer) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (xfer) begin
            sum_d  = add_sum;
            cout_d = add_cout;
            id_d   = gnt_id;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            id_q    <= id_d;
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_sum   = sum_q;
    assign res_cout  = cout_q;
    assign res_id    = id_q;
endmodule
